// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: oversample edge/bit counters, checker strobes, data_valid.
// Define UART_RX_ERR_FLAGS_EN to expose per-frame parity/stop error pulses.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      strt_glitch,
    input  logic                      par_err,
    input  logic                      stp_err,
    output logic                      dat_samp_en,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic                      deser_en,
    output logic                      strt_chk_en,
    output logic                      par_chk_en,
    output logic                      stp_chk_en,
    output logic                      PAR_TYP_Q,
    output logic                      data_valid
`ifdef UART_RX_ERR_FLAGS_EN
    ,
    output logic                      par_err_flag,
    output logic                      stp_err_flag
`endif
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_nxt;

    logic [BW-1:0]             bit_cnt;
    logic [PRESCALE_WIDTH-1:0] p_eff;
    logic                      last_edge;
    logic                      at_cp;
    logic                      start_det;
    logic                      frame_end;
    logic                      par_en_q;
    logic                      par_flag;
    logic                      stp_flag;

    always_comb begin
        case (Prescale)
            PRESCALE_WIDTH'(8),
            PRESCALE_WIDTH'(16),
            PRESCALE_WIDTH'(32): p_eff = Prescale;
            default:             p_eff = PRESCALE_WIDTH'(8);
        endcase
    end

    // >= keeps the counter bounded if Prescale shrinks mid-frame
    assign last_edge   = edge_cnt >= (p_eff - PRESCALE_WIDTH'(1));
    assign at_cp       = edge_cnt == ((p_eff >> 1) + PRESCALE_WIDTH'(2));
    assign dat_samp_en = state != IDLE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        strt_chk_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        start_det   = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (!RX_IN) begin
                    state_nxt = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                strt_chk_en = at_cp;
                if (at_cp && strt_glitch) begin
                    state_nxt = IDLE;
                end else if (last_edge) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                deser_en = at_cp;
                if (last_edge && bit_cnt == LAST_BIT) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                par_chk_en = at_cp;
                if (last_edge) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                stp_chk_en = at_cp;
                if (last_edge) begin
                    frame_end = 1'b1;
                    if (!RX_IN) begin
                        state_nxt = START;
                        start_det = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            par_en_q     <= 1'b0;
            PAR_TYP_Q    <= 1'b0;
            par_flag     <= 1'b0;
            stp_flag     <= 1'b0;
            data_valid   <= 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
            par_err_flag <= 1'b0;
            stp_err_flag <= 1'b0;
`endif
        end else begin
            // flags are read before a back-to-back start clears them
            data_valid   <= frame_end && !par_flag && !stp_flag;
`ifdef UART_RX_ERR_FLAGS_EN
            par_err_flag <= frame_end && par_flag;
            stp_err_flag <= frame_end && stp_flag;
`endif
            if (start_det) begin
                edge_cnt  <= PRESCALE_WIDTH'(1);
                bit_cnt   <= '0;
                par_en_q  <= PAR_EN;
                PAR_TYP_Q <= PAR_TYP;
                par_flag  <= 1'b0;
                stp_flag  <= 1'b0;
            end else if (state_nxt == IDLE) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                edge_cnt <= last_edge ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
                if (state == DATA && last_edge) begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
                if (par_chk_en) begin
                    par_flag <= par_err;
                end
                if (stp_chk_en) begin
                    stp_flag <= stp_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: vector table of whole frames plus reset,
// back-to-back and mid-frame Prescale sequences.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] Prescale = PW'(8);
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          strt_glitch = 1'b0;
    logic          par_err = 1'b0;
    logic          stp_err = 1'b0;
    logic          dat_samp_en;
    logic [PW-1:0] edge_cnt;
    logic          deser_en;
    logic          strt_chk_en;
    logic          par_chk_en;
    logic          stp_chk_en;
    logic          PAR_TYP_Q;
    logic          data_valid;
`ifdef UART_RX_ERR_FLAGS_EN
    logic          par_err_flag;
    logic          stp_err_flag;
`endif

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(PW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .PAR_TYP_Q   (PAR_TYP_Q),
        .data_valid  (data_valid)
`ifdef UART_RX_ERR_FLAGS_EN
        ,
        .par_err_flag(par_err_flag),
        .stp_err_flag(stp_err_flag)
`endif
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        string name;
        int    pre;
        bit    pe;
        bit    pt;
        bit    gl;
        bit    perr;
        bit    serr;
        int    low;
        int    win;
        int    e_strt;
        int    e_deser;
        int    e_par;
        int    e_stp;
        int    e_dv;
        int    e_dvcyc;
        int    e_fdeser;
        int    e_idle;
        int    e_pf;
        int    e_sf;
    } vec_t;

    vec_t vecs[8];

    // Cycle t=0 is the detect cycle; t counts clock periods after it.
    task automatic run_vec(input vec_t v);
        int n_strt = 0, n_deser = 0, n_par = 0, n_stp = 0, n_dv = 0;
        int dvcyc = -1, fdeser = -1, idle = -1, pf = -1, sf = -1;
        int ovl = 0, e1 = -1, typq = -1;
        Prescale    = PW'(v.pre);
        PAR_EN      = v.pe;
        PAR_TYP     = v.pt;
        strt_glitch = v.gl;
        par_err     = v.perr;
        stp_err     = v.serr;
        RX_IN       = 1'b0;
        for (int t = 0; t < v.win; t++) begin
            if (t == v.low) RX_IN = 1'b1;
            if (t == 2) begin
                PAR_EN  = !v.pe;
                PAR_TYP = !v.pt;
            end
            @(negedge CLK);
            n_strt  += int'(strt_chk_en);
            n_deser += int'(deser_en);
            n_par   += int'(par_chk_en);
            n_stp   += int'(stp_chk_en);
            if (int'(strt_chk_en) + int'(deser_en) + int'(par_chk_en)
                + int'(stp_chk_en) > 1) ovl++;
            if (data_valid) begin
                n_dv++;
                if (dvcyc < 0) dvcyc = t;
            end
            if (deser_en && fdeser < 0) fdeser = t;
            if (t > 0 && !dat_samp_en && idle < 0) idle = t;
            if (t == 1) e1 = int'(edge_cnt);
            if (t == 5) typq = int'(PAR_TYP_Q);
`ifdef UART_RX_ERR_FLAGS_EN
            if (par_err_flag && pf < 0) pf = t;
            if (stp_err_flag && sf < 0) sf = t;
`endif
            @(posedge CLK);
            #1;
        end
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
        check({v.name, ".strt_chk"}, n_strt, v.e_strt);
        check({v.name, ".deser"}, n_deser, v.e_deser);
        check({v.name, ".par_chk"}, n_par, v.e_par);
        check({v.name, ".stp_chk"}, n_stp, v.e_stp);
        check({v.name, ".dv_count"}, n_dv, v.e_dv);
        check({v.name, ".dv_cycle"}, dvcyc, v.e_dvcyc);
        check({v.name, ".first_deser"}, fdeser, v.e_fdeser);
        check({v.name, ".idle_cycle"}, idle, v.e_idle);
        check({v.name, ".overlap"}, ovl, 0);
        check({v.name, ".edge_at_1"}, e1, 1);
        check({v.name, ".par_typ_q"}, typq, int'(v.pt));
`ifdef UART_RX_ERR_FLAGS_EN
        check({v.name, ".par_flag_cyc"}, pf, v.e_pf);
        check({v.name, ".stp_flag_cyc"}, sf, v.e_sf);
`endif
    endtask

    initial begin
        int dv1, dv2, ndv, found;
        //          name           pre pe pt gl pe se lo win  st de pa sp dv cyc  fd  idle pf  sf
        vecs[0] = '{"p8_par_a5",    8, 1, 0, 0, 0, 0, 1, 100, 1, 8, 1, 1, 1,  88, 14,  88, -1, -1};
        vecs[1] = '{"p16_nopar_3c",16, 0, 0, 0, 0, 0, 1, 175, 1, 8, 0, 1, 1, 160, 26, 160, -1, -1};
        vecs[2] = '{"p8_par_err",   8, 1, 0, 0, 1, 0, 1, 100, 1, 8, 1, 1, 0,  -1, 14,  88, 88, -1};
        vecs[3] = '{"p8_stp_err",   8, 0, 0, 0, 0, 1, 1,  95, 1, 8, 0, 1, 0,  -1, 14,  80, -1, 80};
        vecs[4] = '{"p8_glitch",    8, 1, 0, 1, 0, 1, 2,  20, 1, 0, 0, 0, 0,  -1, -1,   7, -1, -1};
        vecs[5] = '{"p32_odd",     32, 1, 1, 0, 0, 0, 1, 365, 1, 8, 1, 1, 1, 352, 50, 352, -1, -1};
        vecs[6] = '{"pre5_as8",     5, 0, 0, 0, 0, 0, 1,  95, 1, 8, 0, 1, 1,  80, 14,  80, -1, -1};
        vecs[7] = '{"pre0_both",    0, 1, 1, 0, 1, 1, 1, 100, 1, 8, 1, 1, 0,  -1, 14,  88, 88, 88};

        RST = 1'b1;
        PAR_TYP = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst.samp_en", int'(dat_samp_en), 0);
        check("rst.edge_cnt", int'(edge_cnt), 0);
        check("rst.data_valid", int'(data_valid), 0);
        check("rst.par_typ_q", int'(PAR_TYP_Q), 0);
        check("rst.strobes", int'({deser_en, strt_chk_en, par_chk_en, stp_chk_en}), 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        PAR_TYP = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Next start bit begins the cycle after the stop bit ends
        Prescale = PW'(8);
        PAR_EN   = 1'b1;
        PAR_TYP  = 1'b0;
        RX_IN    = 1'b0;
        dv1 = -1; dv2 = -1; ndv = 0;
        for (int t = 0; t < 190; t++) begin
            if (t == 1) RX_IN = 1'b1;
            if (t == 88) RX_IN = 1'b0;
            if (t == 89) RX_IN = 1'b1;
            @(negedge CLK);
            if (data_valid) begin
                ndv++;
                if (dv1 < 0) dv1 = t;
                else if (dv2 < 0) dv2 = t;
            end
            @(posedge CLK);
            #1;
        end
        check("b2b.dv_count", ndv, 2);
        check("b2b.dv1", dv1, 88);
        check("b2b.dv_gap", dv2 - dv1, 88);

        // Start bit already low on the last stop edge: detect overlaps it
        RX_IN = 1'b0;
        dv1 = -1; dv2 = -1; ndv = 0;
        for (int t = 0; t < 190; t++) begin
            if (t == 1) RX_IN = 1'b1;
            if (t == 87) RX_IN = 1'b0;
            if (t == 88) RX_IN = 1'b1;
            @(negedge CLK);
            if (data_valid) begin
                ndv++;
                if (dv1 < 0) dv1 = t;
                else if (dv2 < 0) dv2 = t;
            end
            @(posedge CLK);
            #1;
        end
        check("ovl_start.dv_count", ndv, 2);
        check("ovl_start.dv2", dv2, 175);

        // Reset during DATA bit 3
        PAR_TYP = 1'b1;
        RX_IN   = 1'b0;
        for (int t = 0; t < 35; t++) begin
            if (t == 1) RX_IN = 1'b1;
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        check("mid_rst.pre_samp_en", int'(dat_samp_en), 1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("mid_rst.samp_en", int'(dat_samp_en), 0);
        check("mid_rst.edge_cnt", int'(edge_cnt), 0);
        check("mid_rst.par_typ_q", int'(PAR_TYP_Q), 0);
        check("mid_rst.outs", int'({deser_en, strt_chk_en, par_chk_en,
                                    stp_chk_en, data_valid}), 0);
        @(posedge CLK);
        #1;
        vecs[0].name = "after_rst";
        run_vec(vecs[0]);

        // Prescale shrinks mid-frame: must still drain to IDLE
        Prescale = PW'(32);
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        found    = 0;
        for (int t = 0; t < 640 && found == 0; t++) begin
            if (t == 1) RX_IN = 1'b1;
            if (t == 10) Prescale = PW'(8);
            @(negedge CLK);
            if (t > 10 && !dat_samp_en) found = 1;
            @(posedge CLK);
            #1;
        end
        check("pre_change.idle", found, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
